// File: rtl/rank_argmax_stream_if.sv
// ============================================================================
// rank_argmax_stream_if : score-in / result-out handshake bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface rank_argmax_stream_if #(
  parameter int W    = 8,
  parameter int N    = 8,
  parameter int IDXW = 3
);
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_score;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_max;
  logic [IDXW-1:0] out_idx;
  logic            out_tie;
  logic            out_trunc;

  modport master (
    output in_valid, in_score, in_last, out_ready,
    input  in_ready, out_valid, out_max, out_idx, out_tie, out_trunc
  );

  modport slave (
    input  in_valid, in_score, in_last, out_ready,
    output in_ready, out_valid, out_max, out_idx, out_tie, out_trunc
  );
endinterface

`default_nettype wire

// File: rtl/rank_argmax_stream.sv
// ============================================================================
// rank_argmax_stream : streaming argmax over a frame of rank scores
// Rev 1.0
// ============================================================================
`default_nettype none

module rank_argmax_stream #(
  parameter int W    = 8,
  parameter int N    = 8,
  parameter int IDXW = 3
) (
  input  wire                   clk,
  input  wire                   rst_n,
  rank_argmax_stream_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [IDXW:0] C_LAST_IDX = (IDXW+1)'(N-1);
  localparam logic [IDXW:0] C_ONE      = (IDXW+1)'(1);

  state_t          state_q, state_d;
  logic [IDXW:0]   cnt_q, cnt_d;
  logic [W-1:0]    max_q, max_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            tie_q, tie_d;
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_max_q, out_max_d;
  logic [IDXW-1:0] out_idx_q, out_idx_d;
  logic            out_tie_q, out_tie_d;
  logic            out_trunc_q, out_trunc_d;

  logic            accept;
  logic            cmp_gt, cmp_eq;
  logic [W-1:0]    cand_max;
  logic [IDXW-1:0] cand_idx;
  logic            cand_tie;
  logic            frame_end;

  assign bus.in_ready  = (state_q != HOLD);
  assign bus.out_valid = out_valid_q;
  assign bus.out_max   = out_max_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_tie   = out_tie_q;
  assign bus.out_trunc = out_trunc_q;

  assign accept = bus.in_valid && (state_q != HOLD);
  assign cmp_gt = (bus.in_score > max_q);
  assign cmp_eq = (bus.in_score == max_q);

  // Candidate result if the current beat were applied; the first beat of a
  // frame seeds the running maximum unconditionally.
  always_comb begin
    cand_max  = max_q;
    cand_idx  = idx_q;
    cand_tie  = tie_q;
    frame_end = 1'b0;
    if (state_q == IDLE) begin
      cand_max  = bus.in_score;
      cand_idx  = '0;
      cand_tie  = 1'b0;
      frame_end = bus.in_last;
    end else begin
      if (cmp_gt) begin
        cand_max = bus.in_score;
        cand_idx = cnt_q[IDXW-1:0];
        cand_tie = 1'b0;
      end else if (cmp_eq) begin
        cand_tie = 1'b1;
      end
      frame_end = bus.in_last || (cnt_q == C_LAST_IDX);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    max_d       = max_q;
    idx_d       = idx_q;
    tie_d       = tie_q;
    out_valid_d = out_valid_q;
    out_max_d   = out_max_q;
    out_idx_d   = out_idx_q;
    out_tie_d   = out_tie_q;
    out_trunc_d = out_trunc_q;

    if (accept) begin
      max_d = cand_max;
      idx_d = cand_idx;
      tie_d = cand_tie;
      cnt_d = (state_q == IDLE) ? C_ONE : cnt_q + C_ONE;
      if (frame_end) begin
        out_max_d   = cand_max;
        out_idx_d   = cand_idx;
        out_tie_d   = cand_tie;
        out_trunc_d = !bus.in_last;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end else begin
        state_d     = ACCUM;
      end
    end else if (state_q == HOLD && out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
      state_d     = IDLE;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      max_q       <= '0;
      idx_q       <= '0;
      tie_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_max_q   <= '0;
      out_idx_q   <= '0;
      out_tie_q   <= 1'b0;
      out_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      max_q       <= max_d;
      idx_q       <= idx_d;
      tie_q       <= tie_d;
      out_valid_q <= out_valid_d;
      out_max_q   <= out_max_d;
      out_idx_q   <= out_idx_d;
      out_tie_q   <= out_tie_d;
      out_trunc_q <= out_trunc_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rank_argmax_stream.sv
// ============================================================================
// tb_rank_argmax_stream : directed self-checking bench for rank_argmax_stream
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rank_argmax_stream;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rank_argmax_stream_if #(.W(8), .N(8), .IDXW(3)) bus ();

  rank_argmax_stream #(.W(8), .N(8), .IDXW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one beat; inputs change 1 time unit after an edge, outputs are
  // sampled 1 time unit after the accepting edge.
  task automatic send_beat(input logic [7:0] score, input logic last);
    bus.in_valid = 1'b1;
    bus.in_score = score;
    bus.in_last  = last;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
    checks++; if (bus.out_max !== 8'd0) begin errors++; $display("FAIL reset_out_max got %0d want 0", bus.out_max); end
    checks++; if (bus.out_idx !== 3'd0) begin errors++; $display("FAIL reset_out_idx got %0d want 0", bus.out_idx); end
    checks++; if (bus.out_tie !== 1'b0) begin errors++; $display("FAIL reset_out_tie got %0b want 0", bus.out_tie); end
    checks++; if (bus.out_trunc !== 1'b0) begin errors++; $display("FAIL reset_out_trunc got %0b want 0", bus.out_trunc); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); end
  endtask

  task automatic consume(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL %s_drop_valid got %0b want 0", tag, bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready got %0b want 1", tag, bus.in_ready); end
  endtask

  task automatic test_ascending;
    send_beat(8'd10, 1'b0);
    send_beat(8'd20, 1'b0);
    send_beat(8'd30, 1'b0);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL asc_early_valid got %0b want 0", bus.out_valid); end
    send_beat(8'd40, 1'b1);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL asc_valid got %0b want 1", bus.out_valid); end
    checks++; if (bus.out_max !== 8'd40) begin errors++; $display("FAIL asc_max got %0d want 40", bus.out_max); end
    checks++; if (bus.out_idx !== 3'd3) begin errors++; $display("FAIL asc_idx got %0d want 3", bus.out_idx); end
    checks++; if (bus.out_tie !== 1'b0) begin errors++; $display("FAIL asc_tie got %0b want 0", bus.out_tie); end
    checks++; if (bus.out_trunc !== 1'b0) begin errors++; $display("FAIL asc_trunc got %0b want 0", bus.out_trunc); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL asc_hold_ready got %0b want 0", bus.in_ready); end
    consume("asc");
    checks++; if (bus.out_max !== 8'd40 || bus.out_idx !== 3'd3) begin errors++; $display("FAIL asc_retain got max %0d idx %0d want 40 3", bus.out_max, bus.out_idx); end
  endtask

  task automatic test_tie;
    send_beat(8'd50, 1'b0);
    send_beat(8'd200, 1'b0);
    send_beat(8'd7, 1'b0);
    send_beat(8'd200, 1'b0);
    send_beat(8'd199, 1'b1);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL tie_valid got %0b want 1", bus.out_valid); end
    checks++; if (bus.out_max !== 8'd200) begin errors++; $display("FAIL tie_max got %0d want 200", bus.out_max); end
    checks++; if (bus.out_idx !== 3'd1) begin errors++; $display("FAIL tie_idx got %0d want 1", bus.out_idx); end
    checks++; if (bus.out_tie !== 1'b1) begin errors++; $display("FAIL tie_flag got %0b want 1", bus.out_tie); end
    consume("tie");
    send_beat(8'd5, 1'b0);
    send_beat(8'd5, 1'b0);
    send_beat(8'd9, 1'b1);
    checks++; if (bus.out_max !== 8'd9) begin errors++; $display("FAIL tie2_max got %0d want 9", bus.out_max); end
    checks++; if (bus.out_idx !== 3'd2) begin errors++; $display("FAIL tie2_idx got %0d want 2", bus.out_idx); end
    checks++; if (bus.out_tie !== 1'b0) begin errors++; $display("FAIL tie2_flag got %0b want 0", bus.out_tie); end
    consume("tie2");
  endtask

  task automatic test_trunc;
    for (int i = 0; i < 7; i++) send_beat(8'(i), 1'b0);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL trunc_early_valid got %0b want 0", bus.out_valid); end
    send_beat(8'd7, 1'b0);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL trunc_valid got %0b want 1", bus.out_valid); end
    checks++; if (bus.out_max !== 8'd7) begin errors++; $display("FAIL trunc_max got %0d want 7", bus.out_max); end
    checks++; if (bus.out_idx !== 3'd7) begin errors++; $display("FAIL trunc_idx got %0d want 7", bus.out_idx); end
    checks++; if (bus.out_trunc !== 1'b1) begin errors++; $display("FAIL trunc_flag got %0b want 1", bus.out_trunc); end
    checks++; if (bus.out_tie !== 1'b0) begin errors++; $display("FAIL trunc_tie got %0b want 0", bus.out_tie); end
    consume("trunc");
    send_beat(8'd255, 1'b1);
    checks++; if (bus.out_max !== 8'd255) begin errors++; $display("FAIL trunc2_max got %0d want 255", bus.out_max); end
    checks++; if (bus.out_idx !== 3'd0) begin errors++; $display("FAIL trunc2_idx got %0d want 0", bus.out_idx); end
    checks++; if (bus.out_trunc !== 1'b0) begin errors++; $display("FAIL trunc2_flag got %0b want 0", bus.out_trunc); end
    consume("trunc2");
  endtask

  task automatic test_backpressure;
    send_beat(8'd1, 1'b0);
    send_beat(8'd2, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_score = 8'd77;
    bus.in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc %0d got %0b want 0", c, bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b1 || bus.out_max !== 8'd2 || bus.out_idx !== 3'd1) begin
        errors++; $display("FAIL bp_stable cyc %0d got v%0b max %0d idx %0d want v1 2 1", c, bus.out_valid, bus.out_max, bus.out_idx);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drop got %0b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got %0b want 1", bus.in_ready); end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_max !== 8'd77 || bus.out_idx !== 3'd0) begin
      errors++; $display("FAIL bp_held_beat got v%0b max %0d idx %0d want v1 77 0", bus.out_valid, bus.out_max, bus.out_idx);
    end
    consume("bp");
  endtask

  task automatic test_reset_mid;
    send_beat(8'd90, 1'b0);
    send_beat(8'd10, 1'b0);
    send_beat(8'd20, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_state got v%0b rdy %0b want v0 rdy1", bus.out_valid, bus.in_ready);
    end
    send_beat(8'd4, 1'b0);
    send_beat(8'd3, 1'b1);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_valid got %0b want 1", bus.out_valid); end
    checks++; if (bus.out_max !== 8'd4) begin errors++; $display("FAIL rstmid_max got %0d want 4", bus.out_max); end
    checks++; if (bus.out_idx !== 3'd0) begin errors++; $display("FAIL rstmid_idx got %0d want 0", bus.out_idx); end
    consume("rstmid");
  endtask

  task automatic test_ignored_last;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b1;
    bus.in_score = 8'd99;
    @(posedge clk);
    #1;
    bus.in_last = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL idle_last got %0b want 0", bus.out_valid); end
    send_beat(8'd8, 1'b1);
    checks++; if (bus.out_max !== 8'd8 || bus.out_tie !== 1'b0) begin
      errors++; $display("FAIL single_beat got max %0d tie %0b want 8 0", bus.out_max, bus.out_tie);
    end
    consume("single");
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_score  = 8'd0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_ascending();
    test_tie();
    test_trunc();
    test_backpressure();
    test_reset_mid();
    test_ignored_last();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
